itch_multichannel_parser: RTL and testbench

//   Multi-feed successor to the single-stream market data processor. Accepts NUM_CH independent

---
 rtl/itch_multichannel_parser.sv | 244 ++++++++++++++++++++++++
 tb/tb_itch_multichannel_parser.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itch_multichannel_parser.sv
// itch_multichannel_parser
//   Multi-feed ITCH front end. Each of NUM_CH 64-bit feeds is buffered in its own
//   FIFO, and each push is checked for sequence continuity on that channel. A round-robin
//   arbiter moves buffered messages into a single registered book-update stream with
//   valid/ready backpressure. Unknown message types are dropped at decode time and
//   reported with a one-cycle error pulse.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    per-channel push handshake (in_ready = FIFO not full)
//   in_data              per channel {symbol[63:32], price[31:0]}, ch i at [64i+:64]
//   in_type, in_seq      per-channel ITCH type byte and sequence number
//   out_valid/out_ready  decoded update handshake
//   out_channel, out_symbol, out_price, out_action, out_seq   decoded update fields
//   err_valid, err_channel   one-cycle pulse for a discarded unknown-type message
//   msgs_accepted, parse_errors, seq_gaps   saturating statistics counters
module itch_multichannel_parser #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int SEQ_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           in_valid,
    input  logic [NUM_CH*64-1:0]        in_data,
    input  logic [NUM_CH*8-1:0]         in_type,
    input  logic [NUM_CH*SEQ_WIDTH-1:0] in_seq,
    output logic [NUM_CH-1:0]           in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2:0]                  out_channel,
    output logic [31:0]                 out_symbol,
    output logic [31:0]                 out_price,
    output logic [2:0]                  out_action,
    output logic [SEQ_WIDTH-1:0]        out_seq,
    output logic                        err_valid,
    output logic [2:0]                  err_channel,
    output logic [CNT_WIDTH-1:0]        msgs_accepted,
    output logic [CNT_WIDTH-1:0]        parse_errors,
    output logic [CNT_WIDTH-1:0]        seq_gaps
);

    localparam int IDX_W   = $clog2(NUM_CH);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    // FIFO entry layout: {type[7:0], symbol[31:0], price[31:0], seq}
    localparam int ENTRY_W = 8 + 64 + SEQ_WIDTH;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    // Channel index reached by stepping 'off' places past 'base', wrapping at NUM_CH.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int sum_v;
        sum_v = (int'(base) + off) % NUM_CH;
        return IDX_W'(sum_v);
    endfunction

    // ITCH type byte to book action; 0 marks an unknown type.
    function automatic logic [2:0] decode_action(input logic [7:0] t);
        logic [2:0] a;
        case (t)
            8'h41:   a = 3'd1;
            8'h45:   a = 3'd2;
            8'h58:   a = 3'd3;
            8'h44:   a = 3'd4;
            default: a = 3'd0;
        endcase
        return a;
    endfunction

    // Add that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_WIDTH]) begin
            return '1;
        end else begin
            return s[CNT_WIDTH-1:0];
        end
    endfunction

    // Number of set bits in a per-channel vector.
    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = c + CNT_WIDTH'(v[i]);
        end
        return c;
    endfunction

    logic [ENTRY_W-1:0]   mem_r     [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r  [NUM_CH];
    logic [PTR_W-1:0]     rd_ptr_r  [NUM_CH];
    logic [OCC_W-1:0]     occ_r     [NUM_CH];
    logic [OCC_W-1:0]     occ_next_s[NUM_CH];
    logic [SEQ_WIDTH-1:0] exp_seq_r [NUM_CH];
    logic [NUM_CH-1:0]    seen_r;
    logic [IDX_W-1:0]     rr_ptr_r;

    logic [NUM_CH-1:0]    push_s;
    logic [NUM_CH-1:0]    pop_s;
    logic [NUM_CH-1:0]    gap_s;
    logic                 grant_any_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic [ENTRY_W-1:0]   head_s;
    logic [2:0]           head_act_s;
    logic                 parse_err_s;

    // Push qualification and sequence-continuity check on the incoming messages.
    always_comb begin
        push_s = '0;
        gap_s  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            push_s[i] = in_valid[i] & in_ready[i];
            gap_s[i]  = push_s[i] & seen_r[i] &
                        (in_seq[i*SEQ_WIDTH +: SEQ_WIDTH] != exp_seq_r[i]);
        end
    end

    // Round-robin grant over non-empty FIFOs whenever the output register can take a new entry.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        pop_s       = '0;
        if (!out_valid || out_ready) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!grant_any_s && (occ_r[rr_idx(rr_ptr_r, k)] != '0)) begin
                    grant_any_s = 1'b1;
                    grant_idx_s = rr_idx(rr_ptr_r, k);
                end else begin
                    grant_any_s = grant_any_s;
                end
            end
            pop_s[grant_idx_s] = grant_any_s;
        end else begin
            pop_s = '0;
        end
        head_s      = mem_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
        head_act_s  = decode_action(head_s[ENTRY_W-1 -: 8]);
        parse_err_s = grant_any_s && (head_act_s == 3'd0);
    end

    // Next occupancy per channel from this cycle's push/pop pair.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            case ({push_s[i], pop_s[i]})
                2'b10:   occ_next_s[i] = occ_r[i] + OCC_W'(1);
                2'b01:   occ_next_s[i] = occ_r[i] - OCC_W'(1);
                default: occ_next_s[i] = occ_r[i];
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= {in_type[i*8 +: 8], in_data[i*64 +: 64],
                                          in_seq[i*SEQ_WIDTH +: SEQ_WIDTH]};
            end
        end
    end

    // FIFO pointers, occupancy, registered in_ready and per-channel expected sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_r[i]  <= '0;
                rd_ptr_r[i]  <= '0;
                occ_r[i]     <= '0;
                exp_seq_r[i] <= '0;
            end
            seen_r   <= '0;
            in_ready <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i]  <= wr_ptr_r[i] + PTR_W'(1);
                    // Resynchronise on every push so one gap is counted once.
                    exp_seq_r[i] <= in_seq[i*SEQ_WIDTH +: SEQ_WIDTH] + SEQ_WIDTH'(1);
                    seen_r[i]    <= 1'b1;
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
                end
                occ_r[i]    <= occ_next_s[i];
                in_ready[i] <= (occ_next_s[i] != OCC_FULL);
            end
        end
    end

    // Output register, error pulse and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_channel <= 3'd0;
            out_symbol  <= 32'd0;
            out_price   <= 32'd0;
            out_action  <= 3'd0;
            out_seq     <= '0;
            err_valid   <= 1'b0;
            err_channel <= 3'd0;
            rr_ptr_r    <= '0;
        end else begin
            err_valid <= 1'b0;
            if (grant_any_s) begin
                rr_ptr_r <= rr_idx(grant_idx_s, 1);
                if (!parse_err_s) begin
                    out_valid   <= 1'b1;
                    out_channel <= 3'(grant_idx_s);
                    out_action  <= head_act_s;
                    out_symbol  <= head_s[SEQ_WIDTH+32 +: 32];
                    out_price   <= head_s[SEQ_WIDTH +: 32];
                    out_seq     <= head_s[SEQ_WIDTH-1:0];
                end else begin
                    // Unknown type uses the slot but produces no update.
                    out_valid   <= 1'b0;
                    err_valid   <= 1'b1;
                    err_channel <= 3'(grant_idx_s);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
        end
    end

    // Saturating statistics; same-edge events on several channels add together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msgs_accepted <= '0;
            parse_errors  <= '0;
            seq_gaps      <= '0;
        end else begin
            msgs_accepted <= sat_add(msgs_accepted, popcount(push_s));
            seq_gaps      <= sat_add(seq_gaps, popcount(gap_s));
            parse_errors  <= sat_add(parse_errors, CNT_WIDTH'(parse_err_s));
        end
    end

endmodule

// File: tb/tb_itch_multichannel_parser.sv
// Bench for itch_multichannel_parser: directed scenarios followed by random traffic,
// checked through a per-channel scoreboard fed at acceptance time and drained by a monitor.
module tb_itch_multichannel_parser;
    localparam int NCH = 4;
    localparam int SW  = 16;
    localparam int CW  = 32;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    in_valid;
    logic [NCH*64-1:0] in_data;
    logic [NCH*8-1:0]  in_type;
    logic [NCH*SW-1:0] in_seq;
    logic [NCH-1:0]    in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_channel;
    logic [31:0]       out_symbol;
    logic [31:0]       out_price;
    logic [2:0]        out_action;
    logic [SW-1:0]     out_seq;
    logic              err_valid;
    logic [2:0]        err_channel;
    logic [CW-1:0]     msgs_accepted;
    logic [CW-1:0]     parse_errors;
    logic [CW-1:0]     seq_gaps;

    itch_multichannel_parser #(.NUM_CH(NCH), .FIFO_DEPTH(8), .SEQ_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_type(in_type),
        .in_seq(in_seq), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_channel(out_channel), .out_symbol(out_symbol), .out_price(out_price),
        .out_action(out_action), .out_seq(out_seq), .err_valid(err_valid),
        .err_channel(err_channel), .msgs_accepted(msgs_accepted),
        .parse_errors(parse_errors), .seq_gaps(seq_gaps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        bit          is_err;
        logic [2:0]  act;
        logic [31:0] sym;
        logic [31:0] price;
        logic [15:0] seq;
    } exp_t;

    exp_t        sb[$];
    int          chan_log[$];
    int          errors = 0;
    int          checks = 0;
    int          m_acc, m_perr, m_gaps, err_pulses;
    bit          m_seen[NCH];
    int          m_exp[NCH];
    logic        hold_prev;
    logic [85:0] hold_val;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        end
    endtask

    function automatic logic [2:0] ref_action(input logic [7:0] t);
        if (t == 8'h41) return 3'd1;
        if (t == 8'h45) return 3'd2;
        if (t == 8'h58) return 3'd3;
        if (t == 8'h44) return 3'd4;
        return 3'd0;
    endfunction

    task automatic flush();
        sb.delete();
        chan_log.delete();
        m_acc = 0; m_perr = 0; m_gaps = 0; err_pulses = 0;
        for (int i = 0; i < NCH; i++) begin
            m_seen[i] = 1'b0;
            m_exp[i]  = 0;
        end
    endtask

    // Reference: record an accepted message and update the expected statistics.
    task automatic model_push(input int ch, input logic [7:0] t, input logic [63:0] d, input logic [15:0] s);
        exp_t e;
        m_acc++;
        if (m_seen[ch] && int'(s) != m_exp[ch]) m_gaps++;
        m_seen[ch] = 1'b1;
        m_exp[ch]  = (int'(s) + 1) % 65536;
        e.ch = ch; e.act = ref_action(t); e.is_err = (e.act == 3'd0);
        e.sym = d[63:32]; e.price = d[31:0]; e.seq = s;
        if (e.is_err) m_perr++;
        sb.push_back(e);
    endtask

    // Match a DUT event against the oldest expected entry of its channel.
    task automatic sb_match(input bit is_err, input int ch);
        int   idx;
        exp_t e;
        idx = -1;
        for (int k = 0; k < sb.size(); k++) begin
            if (idx < 0 && sb[k].ch == ch) idx = k;
        end
        check("sb_expected_entry", 128'(idx >= 0), 128'(1));
        if (idx >= 0) begin
            e = sb[idx];
            sb.delete(idx);
            check("event_kind_err", 128'(is_err), 128'(e.is_err));
            if (!is_err && !e.is_err) begin
                check("out_action", 128'(out_action), 128'(e.act));
                check("out_symbol", 128'(out_symbol), 128'(e.sym));
                check("out_price", 128'(out_price), 128'(e.price));
                check("out_seq", 128'(out_seq), 128'(e.seq));
            end
        end
        if (!is_err) chan_log.push_back(ch);
    endtask

    // Monitor: handshakes, error pulses and stability under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                check("hold_stable", 128'({out_valid, out_channel, out_action, out_symbol, out_price, out_seq}),
                      128'({1'b1, hold_val}));
            if (out_valid && out_ready) sb_match(1'b0, int'(out_channel));
            if (err_valid) begin
                err_pulses++;
                sb_match(1'b1, int'(err_channel));
            end
            hold_prev = out_valid && !out_ready;
            hold_val  = {out_channel, out_action, out_symbol, out_price, out_seq};
        end
    end

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            if (in_valid[i] && in_ready[i])
                model_push(i, in_type[i*8 +: 8], in_data[i*64 +: 64], in_seq[i*SW +: SW]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_msg(input int ch, input logic [7:0] t, input logic [31:0] sym,
                           input logic [31:0] pr, input logic [15:0] s);
        in_valid[ch]         = 1'b1;
        in_type[ch*8 +: 8]   = t;
        in_data[ch*64 +: 64] = {sym, pr};
        in_seq[ch*SW +: SW]  = s;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        in_valid  = '0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        tick();
        check({name, "_drained"}, 128'(sb.size()), 128'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        flush();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0]  rt;
        logic [15:0] rs;
        int          pick;
        rst = 1'b1; in_valid = '0; in_data = '0; in_type = '0; in_seq = '0; out_ready = 1'b1;
        hold_prev = 1'b0; hold_val = '0;
        flush();

        // Reset state
        do_reset();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_err_valid", 128'(err_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(4'hF));
        check("rst_counters", 128'({msgs_accepted, parse_errors, seq_gaps}), 128'(0));

        // Single Add message: visible one edge after acceptance
        set_msg(0, 8'h41, 32'h41415054, 32'h32000000, 16'd5);
        tick();
        in_valid = '0;
        @(posedge clk);
        #1;
        check("t1_latency_valid", 128'(out_valid), 128'(1));
        check("t1_fields", 128'({out_channel, out_action, out_symbol, out_price, out_seq}),
              128'({3'd0, 3'd1, 32'h41415054, 32'h32000000, 16'd5}));
        drain("t1");

        // All channels at once: round-robin order 0..3
        do_reset();
        for (int i = 0; i < NCH; i++) set_msg(i, 8'h45, 32'h10 + 32'(i), 32'h100 + 32'(i), 16'(i));
        tick();
        drain("t2");
        check("t2_count", 128'(chan_log.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < chan_log.size()) check("t2_order", 128'(chan_log[i]), 128'(i));
        end
        check("t2_msgs_accepted", 128'(msgs_accepted), 128'(4));

        // Backpressure: ch2 fills; the output register holds one, FIFO holds eight
        do_reset();
        out_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
            check("t3_in_ready", 128'(in_ready[2]), 128'(j < 9));
            set_msg(2, 8'h41, 32'h53000000 + 32'(j), 32'(j), 16'(100 + j));
            tick();
        end
        in_valid = '0;
        for (int j = 0; j < 4; j++) tick();
        check("t3_hold_valid", 128'(out_valid), 128'(1));
        check("t3_hold_symbol", 128'(out_symbol), 128'(32'h53000000));
        check("t3_still_full", 128'(in_ready[2]), 128'(0));
        drain("t3");
        check("t3_delivered", 128'(chan_log.size()), 128'(9));
        check("t3_msgs_accepted", 128'(msgs_accepted), 128'(9));

        // Sequence gaps including wrap
        do_reset();
        set_msg(1, 8'h41, 32'h1, 32'h1, 16'd10);     tick();
        set_msg(1, 8'h41, 32'h2, 32'h2, 16'd11);     tick();
        set_msg(1, 8'h41, 32'h3, 32'h3, 16'd13);     tick();
        set_msg(1, 8'h41, 32'h4, 32'h4, 16'hFFFF);   tick();
        set_msg(1, 8'h41, 32'h5, 32'h5, 16'h0000);   tick();
        drain("t4");
        check("t4_seq_gaps", 128'(seq_gaps), 128'(2));

        // Unknown type between two cancels on ch3
        do_reset();
        set_msg(3, 8'h58, 32'hA, 32'hA, 16'd1); tick();
        set_msg(3, 8'hFF, 32'hB, 32'hB, 16'd2); tick();
        set_msg(3, 8'h58, 32'hC, 32'hC, 16'd3); tick();
        drain("t5");
        check("t5_err_pulses", 128'(err_pulses), 128'(1));
        check("t5_parse_errors", 128'(parse_errors), 128'(1));
        check("t5_outputs", 128'(chan_log.size()), 128'(2));

        // Asynchronous reset with traffic buffered
        do_reset();
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            set_msg(0, 8'h44, 32'hD0 + 32'(j), 32'(j), 16'(1 + j));
            tick();
        end
        in_valid = '0;
        tick();
        check("t6_pre_valid", 128'(out_valid), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 128'(out_valid), 128'(0));
        check("t6_rst_ready", 128'(in_ready), 128'(4'hF));
        check("t6_rst_counters", 128'({msgs_accepted, parse_errors, seq_gaps}), 128'(0));
        flush();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        set_msg(0, 8'h41, 32'h77, 32'h77, 16'd7);
        tick();
        drain("t6");
        check("t6_no_gap", 128'(seq_gaps), 128'(0));
        check("t6_msgs_accepted", 128'(msgs_accepted), 128'(1));

        // Random traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                in_valid[ch] = 1'b0;
                if ($urandom_range(0, 9) < 4) begin
                    pick = $urandom_range(0, 7);
                    case (pick)
                        0, 4:    rt = 8'h41;
                        1, 5:    rt = 8'h45;
                        2:       rt = 8'h58;
                        3:       rt = 8'h44;
                        default: rt = 8'($urandom);
                    endcase
                    if (m_seen[ch] && $urandom_range(0, 9) != 0) rs = 16'(m_exp[ch]);
                    else rs = 16'($urandom);
                    set_msg(ch, rt, $urandom, $urandom, rs);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("rand");
        check("rand_msgs_accepted", 128'(msgs_accepted), 128'(m_acc));
        check("rand_parse_errors", 128'(parse_errors), 128'(m_perr));
        check("rand_seq_gaps", 128'(seq_gaps), 128'(m_gaps));
        check("rand_err_pulses", 128'(err_pulses), 128'(m_perr));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
